// File: rtl/map_ss_seq_pkg.sv
// Shared definitions for the mapper save-state sequencer:
// bus widths, default transfer length and FSM state encoding.
package map_ss_seq_pkg;

  localparam int BW_ADDR    = 8;
  localparam int BW_DATA    = 8;
  localparam int BW_CNT     = 8;
  localparam int SS_LEN_DEF = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE    = 3'd1,
    LOAD_RD = 3'd2,
    LOAD_WR = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/map_ss_sum.sv
// Checksum accumulator for save-state transfers (mod-256 byte sum).
// Ports: i_clk, i_rst (async high), i_clr, i_add, i_byte -> o_sum.
module map_ss_sum
  import map_ss_seq_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_add,
  input  logic [BW_DATA-1:0] i_byte,
  output logic [BW_DATA-1:0] o_sum
);

  logic [BW_DATA-1:0] r_sum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_byte;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/map_ss_seq.sv
// Mapper save-state sequencer: copies mapper state to a buffer (save)
// or restores it from the buffer (load), one address per word.
// Ports: m2 clk, map_rst async high, start_save/start_load requests,
// busy/done status, ss_* mapper access, buf_* buffer access, ss_sum.
// Optional checksum accumulator enabled by macro SS_SUM_EN.
module map_ss_seq
  import map_ss_seq_pkg::*;
#(
  parameter int SS_LEN = SS_LEN_DEF
) (
  input  logic               m2,
  input  logic               map_rst,
  input  logic               start_save,
  input  logic               start_load,
  output logic               busy,
  output logic               done,
  output logic               ss_act,
  output logic               ss_we,
  output logic [BW_ADDR-1:0] ss_addr,
  output logic [BW_DATA-1:0] ss_wdat,
  input  logic [BW_DATA-1:0] ss_rdat,
  output logic [BW_ADDR-1:0] buf_addr,
  output logic               buf_we,
  output logic [BW_DATA-1:0] buf_wdat,
  input  logic [BW_DATA-1:0] buf_rdat,
  output logic [BW_DATA-1:0] ss_sum
);

  // Terminal index; for SS_LEN=256 this is 255, so cnt never wraps.
  localparam logic [BW_CNT-1:0] LAST = BW_CNT'(SS_LEN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BW_CNT-1:0] r_cnt;
  logic [BW_CNT-1:0] w_cnt_nxt;
  logic              w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge m2 or posedge map_rst) begin
    if (map_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        // save has priority over a simultaneous load
        if (start_save) begin
          w_state_nxt = SAVE;
          w_cnt_nxt   = '0;
        end else if (start_load) begin
          w_state_nxt = LOAD_RD;
          w_cnt_nxt   = '0;
        end
      end
      SAVE: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      LOAD_RD: begin
        w_state_nxt = LOAD_WR;
      end
      LOAD_WR: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = LOAD_RD;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    ss_act   = 1'b0;
    ss_we    = 1'b0;
    ss_addr  = '0;
    ss_wdat  = '0;
    buf_addr = '0;
    buf_we   = 1'b0;
    buf_wdat = '0;
    unique case (r_state)
      IDLE: begin
      end
      SAVE: begin
        busy     = 1'b1;
        ss_act   = 1'b1;
        ss_addr  = r_cnt;
        buf_addr = r_cnt;
        buf_we   = 1'b1;
        buf_wdat = ss_rdat;
      end
      LOAD_RD: begin
        // buffer read issued here; data returns in LOAD_WR
        busy     = 1'b1;
        ss_act   = 1'b1;
        ss_addr  = r_cnt;
        buf_addr = r_cnt;
      end
      LOAD_WR: begin
        busy     = 1'b1;
        ss_act   = 1'b1;
        ss_we    = 1'b1;
        ss_addr  = r_cnt;
        ss_wdat  = buf_rdat;
        buf_addr = r_cnt;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef SS_SUM_EN
  logic               w_sum_clr;
  logic               w_sum_add;
  logic [BW_DATA-1:0] w_sum_byte;

  assign w_sum_clr  = (r_state == IDLE) &&
                      (start_save || start_load);
  assign w_sum_add  = (r_state == SAVE) ||
                      (r_state == LOAD_WR);
  assign w_sum_byte = (r_state == SAVE) ? ss_rdat
                                        : buf_rdat;

  map_ss_sum u_sum (
    .i_clk  (m2),
    .i_rst  (map_rst),
    .i_clr  (w_sum_clr),
    .i_add  (w_sum_add),
    .i_byte (w_sum_byte),
    .o_sum  (ss_sum)
  );
`else
  assign ss_sum = '0;
`endif

endmodule

// File: tb/tb_map_ss_seq.sv
// Scoreboard bench for map_ss_seq: stimulus pushes expected
// buffer/mapper writes and done events; a monitor pops and compares.
module tb_map_ss_seq;

  localparam int LEN = 128;
`ifdef SS_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  localparam int K_BUF  = 0;
  localparam int K_SS   = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    int addr;
    int data;
  } exp_t;

  logic       m2;
  logic       map_rst;
  logic       start_save;
  logic       start_load;
  logic       busy;
  logic       done;
  logic       ss_act;
  logic       ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;
  logic [7:0] buf_addr;
  logic       buf_we;
  logic [7:0] buf_wdat;
  logic [7:0] buf_rdat;
  logic [7:0] ss_sum;

  logic       start3;
  logic       busy3;
  logic       done3;
  logic       ss_act3;
  logic       ss_we3;
  logic [7:0] ss_addr3;
  logic [7:0] ss_wdat3;
  logic [7:0] ss_rdat3;
  logic [7:0] buf_addr3;
  logic       buf_we3;
  logic [7:0] buf_wdat3;
  logic [7:0] buf_rdat3;
  logic [7:0] ss_sum3;

  map_ss_seq #(.SS_LEN(LEN)) u_dut (
    .m2         (m2),
    .map_rst    (map_rst),
    .start_save (start_save),
    .start_load (start_load),
    .busy       (busy),
    .done       (done),
    .ss_act     (ss_act),
    .ss_we      (ss_we),
    .ss_addr    (ss_addr),
    .ss_wdat    (ss_wdat),
    .ss_rdat    (ss_rdat),
    .buf_addr   (buf_addr),
    .buf_we     (buf_we),
    .buf_wdat   (buf_wdat),
    .buf_rdat   (buf_rdat),
    .ss_sum     (ss_sum)
  );

  map_ss_seq #(.SS_LEN(3)) u_dut3 (
    .m2         (m2),
    .map_rst    (map_rst),
    .start_save (start3),
    .start_load (1'b0),
    .busy       (busy3),
    .done       (done3),
    .ss_act     (ss_act3),
    .ss_we      (ss_we3),
    .ss_addr    (ss_addr3),
    .ss_wdat    (ss_wdat3),
    .ss_rdat    (ss_rdat3),
    .buf_addr   (buf_addr3),
    .buf_we     (buf_we3),
    .buf_wdat   (buf_wdat3),
    .buf_rdat   (buf_rdat3),
    .ss_sum     (ss_sum3)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  // mapper model: registers taken on negedge
  logic [7:0] prg     = 8'hFF;
  logic       mirror  = 1'b1;
  logic [7:0] map_idx = 8'd177;

  always_comb begin
    ss_rdat = 8'hFF;
    if (ss_addr == 8'd0) ss_rdat = prg;
    else if (ss_addr == 8'd1) ss_rdat = {7'd0, mirror};
    else if (ss_addr == 8'd127) ss_rdat = map_idx;
  end

  always @(negedge m2) begin
    if (ss_act && ss_we) begin
      if (ss_addr == 8'd0) prg <= ss_wdat;
      if (ss_addr == 8'd1) mirror <= ss_wdat[0];
      if (ss_addr == 8'd127) map_idx <= ss_wdat;
    end
  end

  always_comb begin
    ss_rdat3 = 8'h00;
    if (ss_addr3 == 8'd0) ss_rdat3 = 8'hFF;
    else if (ss_addr3 == 8'd1) ss_rdat3 = 8'h01;
    else if (ss_addr3 == 8'd2) ss_rdat3 = 8'hB1;
  end
  assign buf_rdat3 = 8'h00;

  // buffer model with a bench-side fill port
  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_wa;
  logic [7:0] tb_wd;

  always @(posedge m2) begin
    if (buf_we) mem[buf_addr] <= buf_wdat;
    else if (tb_we) mem[tb_wa] <= tb_wd;
    buf_rdat <= mem[buf_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act,
                     input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  nm, act, req);
  endtask

  exp_t q[$];
  int   busy_cyc = 0;

  always @(negedge m2) begin
    exp_t e;
    if (map_rst) begin
      busy_cyc = 0;
    end else begin
      if (busy && !done) busy_cyc++;
      if (buf_we || ss_we || done) begin
        if (q.size() == 0) begin
          chk("unexpected_event",
              int'({buf_we, ss_we, done}), 0);
        end else begin
          e = q.pop_front();
          if (e.kind == K_BUF) begin
            chk("save_kind", int'({ss_we, buf_we, done}), 2);
            chk("save_act", int'(ss_act), 1);
            chk("save_buf_addr", int'(buf_addr), e.addr);
            chk("save_ss_addr", int'(ss_addr), e.addr);
            chk("save_data", int'(buf_wdat), e.data);
          end else if (e.kind == K_SS) begin
            chk("load_kind", int'({ss_we, buf_we, done}), 4);
            chk("load_act", int'(ss_act), 1);
            chk("load_ss_addr", int'(ss_addr), e.addr);
            chk("load_buf_addr", int'(buf_addr), e.addr);
            chk("load_data", int'(ss_wdat), e.data);
          end else begin
            chk("done_flags",
                int'({ss_we, buf_we, done, busy, ss_act}), 6);
            chk("done_cycles", busy_cyc, e.addr);
            chk("done_sum", int'(ss_sum), e.data);
          end
        end
        if (done) busy_cyc = 0;
      end
    end
  end

  function automatic int save_pat(input int i);
    if (i == 0) return 8'hFF;
    if (i == 1) return 8'h01;
    if (i == 127) return 8'hB1;
    return 8'hFF;
  endfunction

  function automatic int ld_pat(input int i);
    if (i == 0) return 8'h05;
    if (i == 1) return 8'h00;
    return (i * 3 + 7) & 255;
  endfunction

  task automatic push_save();
    int s = 0;
    for (int i = 0; i < LEN; i++) begin
      q.push_back('{K_BUF, i, save_pat(i)});
      s += save_pat(i);
    end
    q.push_back('{K_DONE, LEN, SUM_ON ? (s & 255) : 0});
  endtask

  task automatic push_load();
    int s = 0;
    for (int i = 0; i < LEN; i++) begin
      q.push_back('{K_SS, i, ld_pat(i)});
      s += ld_pat(i);
    end
    q.push_back('{K_DONE, 2 * LEN, SUM_ON ? (s & 255) : 0});
  endtask

  task automatic fill_buf();
    for (int i = 0; i < LEN; i++) begin
      @(posedge m2);
      #1;
      tb_we = 1'b1;
      tb_wa = 8'(i);
      tb_wd = 8'(ld_pat(i));
    end
    @(posedge m2);
    #1;
    tb_we = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic l);
    @(posedge m2);
    #1;
    start_save = s;
    start_load = l;
    @(posedge m2);
    #1;
    start_save = 1'b0;
    start_load = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    bit seen = 1'b0;
    for (int n = 0; n < lim; n++) begin
      @(negedge m2);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_timeout"}, int'(seen), 1);
    @(posedge m2);
    #1;
  endtask

  initial begin
    bit seen;
    map_rst    = 1'b1;
    start_save = 1'b0;
    start_load = 1'b0;
    start3     = 1'b0;
    tb_we      = 1'b0;
    tb_wa      = '0;
    tb_wd      = '0;
    repeat (2) @(posedge m2);
    #1;
    chk("rst_flags",
        int'({busy, done, ss_act, ss_we, buf_we}), 0);
    chk("rst_ss_addr", int'(ss_addr), 0);
    chk("rst_buf_addr", int'(buf_addr), 0);
    chk("rst_sum", int'(ss_sum), 0);

    // start raised together with reset release
    push_save();
    map_rst    = 1'b0;
    start_save = 1'b1;
    @(posedge m2);
    #1;
    start_save = 1'b0;
    chk("accept_after_rst", int'(busy), 1);
    wait_done("save", 300);
    chk("buf0", int'(mem[0]), 8'hFF);
    chk("buf1", int'(mem[1]), 8'h01);
    chk("buf5", int'(mem[5]), 8'hFF);
    chk("buf127", int'(mem[127]), 8'hB1);
    chk("idle_after_save", int'(busy), 0);

    // simultaneous starts, then a load during busy
    push_save();
    pulse(1'b1, 1'b1);
    chk("simul_path", int'({buf_we, ss_we}), 2);
    repeat (10) @(posedge m2);
    #1;
    start_load = 1'b1;
    @(posedge m2);
    #1;
    start_load = 1'b0;
    wait_done("simul", 300);
    @(posedge m2);
    #1;
    chk("busy_load_ignored", int'(busy), 0);

    // load
    fill_buf();
    push_load();
    pulse(1'b0, 1'b1);
    wait_done("load", 600);
    chk("prg_loaded", int'(prg), 8'h05);
    chk("mirror_loaded", int'(mirror), 0);
    chk("idx_loaded", int'(map_idx), 8'h84);

    // reset in the middle of a load
    push_load();
    pulse(1'b0, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge m2);
      if (ss_we && ss_addr == 8'd40) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reach_cnt40", int'(seen), 1);
    #2;
    map_rst = 1'b1;
    #1;
    chk("midrst_flags",
        int'({busy, done, ss_act, ss_we, buf_we}), 0);
    chk("midrst_ss_addr", int'(ss_addr), 0);
    chk("midrst_buf_addr", int'(buf_addr), 0);
    chk("midrst_sum", int'(ss_sum), 0);
    q.delete();
    repeat (3) @(posedge m2);
    #1;
    map_rst = 1'b0;
    repeat (3) @(posedge m2);
    #1;
    chk("midrst_idle", int'({busy, done}), 0);
    push_load();
    pulse(1'b0, 1'b1);
    wait_done("load2", 600);

    // three-word checksum instance
    @(posedge m2);
    #1;
    start3 = 1'b1;
    @(posedge m2);
    #1;
    start3 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge m2);
      if (done3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("sum3_timeout", int'(seen), 1);
    chk("sum3", int'(ss_sum3), SUM_ON ? 8'hB1 : 0);
    repeat (3) @(posedge m2);
    #1;
    chk("sum3_hold", int'(ss_sum3), SUM_ON ? 8'hB1 : 0);
    chk("sum3_idle", int'(busy3), 0);

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
